ps2_rx: RTL and testbench

Frame receiver for the PS/2 keyboard link. It synchronises and deglitches the raw PS2_clk/PS2_dat pins and deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop). Each validated byte is presented with a one-cycle strobe. It sits directly upstream of the PS/2 scan-code manager, which consumes `data`/`valid` and decodes key presses.

---
 rtl/ps2_rx.sv | 153 +++++++++++++++
 tb/tb_ps2_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pin sync, clock deglitch, 11-bit deserialiser.
// Optional intra-frame idle timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       PS2_clk,
   input  logic       PS2_dat,
   output logic [7:0] data,
   output logic       valid,
   output logic       err,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   if (FILTER_LEN < 2 || FILTER_LEN > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("ps2_rx: parameter out of range");
   end

   logic       clk_s1, clk_s2, dat_s1, dat_s2;
   logic       fclk, fclk_d, fall;
   logic [3:0] fcnt;

   state_t     state, state_n;
   logic [2:0] bitcnt, bitcnt_n;
   logic [7:0] shift, shift_n;
   logic       par, par_n;
   logic [7:0] data_n;
   logic       valid_n, err_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= PS2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= PS2_dat;
         dat_s2 <= dat_s1;
      end
   end

   // fclk follows clk_s2 only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fclk   <= 1'b1;
         fclk_d <= 1'b1;
         fcnt   <= '0;
      end else begin
         fclk_d <= fclk;
         if (clk_s2 == fclk) begin
            fcnt <= '0;
         end else if (fcnt == 4'(FILTER_LEN - 1)) begin
            fclk <= clk_s2;
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + 4'd1;
         end
      end
   end

   assign fall = fclk_d & ~fclk;
   assign busy = (state != IDLE);

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          expire;

   assign expire = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt <= '0;
      end else if (state == IDLE || fall || expire) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         bitcnt <= '0;
         shift  <= '0;
         par    <= 1'b0;
         data   <= '0;
         valid  <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         bitcnt <= bitcnt_n;
         shift  <= shift_n;
         par    <= par_n;
         data   <= data_n;
         valid  <= valid_n;
         err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      shift_n  = shift;
      par_n    = par;
      data_n   = data;
      valid_n  = 1'b0;
      err_n    = 1'b0;
      if (fall) begin
         unique case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state_n  = DATA;
                  bitcnt_n = '0;
               end
            end
            DATA: begin
               shift_n  = {dat_s2, shift[7:1]};
               bitcnt_n = bitcnt + 3'd1;
               if (bitcnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               par_n   = dat_s2;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (dat_s2 && (^{shift, par})) begin
                  data_n  = shift;
                  valid_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      if (expire) begin
         state_n = IDLE;
         err_n   = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: directed frames queue expected bytes/errors,
// a monitor pops and compares on every valid/err pulse.
module tb_ps2_rx;

   localparam int HALF = 40;
   localparam int TMO  = 600;

   logic       clk = 1'b0;
   logic       reset;
   logic       PS2_clk, PS2_dat;
   logic [7:0] data;
   logic       valid, err, busy;

   typedef struct {
      bit         is_err;
      logic [7:0] d;
   } exp_t;

   exp_t       q[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] last_good = 8'h00;

   ps2_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .PS2_clk(PS2_clk), .PS2_dat(PS2_dat),
      .data(data), .valid(valid), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (!reset && (valid || err)) begin
         chk("valid_err_exclusive", {31'd0, valid & err}, 32'd0);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none",
                     valid, err);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_kind_err", {31'd0, err}, {31'd0, e.is_err});
            chk("pulse_data", {24'd0, data}, {24'd0, e.d});
         end
      end
   end

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int glitch_at,
                             input int nbits);
      logic [10:0] bits;
      exp_t e;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      if (nbits == 11) begin
         e.is_err = bad_par | bad_stop;
         e.d = e.is_err ? last_good : b;
         if (!e.is_err) last_good = b;
         q.push_back(e);
      end
      for (int i = 0; i < nbits; i++) begin
         PS2_dat = bits[i];
         cycles(HALF);
         PS2_clk = 1'b0;
         cycles(HALF);
         if (i == 3) chk("busy_mid_frame", {31'd0, busy}, 32'd1);
         PS2_clk = 1'b1;
         if (i == glitch_at) begin
            cycles(10);
            PS2_clk = 1'b0;
            cycles(2);
            PS2_clk = 1'b1;
            cycles(HALF - 12);
         end else begin
            cycles(HALF);
         end
      end
      PS2_dat = 1'b1;
   endtask

   task automatic drain;
      int t;
      t = 0;
      while (q.size() != 0 && t < 200) begin
         cycles(1);
         t++;
      end
      chk("queue_drained", q.size(), 32'd0);
   endtask

   task automatic chk_outputs_reset(string tag);
      @(negedge clk);
      chk({tag, "_data"}, {24'd0, data}, 32'd0);
      chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      PS2_clk = 1'b1;
      PS2_dat = 1'b1;
      cycles(5);
      chk_outputs_reset("reset");
      reset = 1'b0;
      cycles(20);

      send_frame(8'h1C, 0, 0, -1, 11);
      drain();
      chk("busy_after_1c", {31'd0, busy}, 32'd0);
      chk("data_1c", {24'd0, data}, 32'h1C);

      send_frame(8'hF0, 0, 0, -1, 11);
      cycles(200);
      send_frame(8'h1C, 0, 0, -1, 11);
      drain();
      chk("data_b2b_1c", {24'd0, data}, 32'h1C);

      send_frame(8'hF0, 0, 0, -1, 11);
      send_frame(8'h1C, 1, 0, -1, 11);
      drain();
      chk("data_hold_bad_par", {24'd0, data}, 32'hF0);
      send_frame(8'h1C, 0, 1, -1, 11);
      drain();
      chk("data_hold_bad_stop", {24'd0, data}, 32'hF0);
      chk("busy_after_err", {31'd0, busy}, 32'd0);

      PS2_clk = 1'b0;
      cycles(2);
      PS2_clk = 1'b1;
      cycles(50);
      chk("busy_after_idle_glitch", {31'd0, busy}, 32'd0);
      send_frame(8'h5A, 0, 0, 3, 11);
      drain();
      chk("data_5a_glitch", {24'd0, data}, 32'h5A);

`ifdef PS2_RX_TIMEOUT_EN
      begin
         exp_t e;
         e.is_err = 1'b1;
         e.d = last_good;
         q.push_back(e);
      end
      send_frame(8'h33, 0, 0, -1, 5);
      cycles(TMO + 200);
      drain();
      chk("busy_after_timeout", {31'd0, busy}, 32'd0);
      send_frame(8'h29, 0, 0, -1, 11);
      drain();
      chk("data_29", {24'd0, data}, 32'h29);
`else
      send_frame(8'h33, 0, 0, -1, 5);
      cycles(TMO + 200);
      chk("busy_stuck_no_timeout", {31'd0, busy}, 32'd1);
      chk("data_hold_partial", {24'd0, data}, 32'h5A);
`endif

      send_frame(8'h33, 0, 0, -1, 5);
      reset = 1'b1;
      cycles(3);
      chk_outputs_reset("midreset");
      reset = 1'b0;
      last_good = 8'h00;
      cycles(20);
      chk("busy_after_release", {31'd0, busy}, 32'd0);
      send_frame(8'h1C, 0, 0, -1, 11);
      drain();
      chk("data_1c_after_reset", {24'd0, data}, 32'h1C);

      cycles(20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
